rtc_time_counter: RTL
=====================

Name: rtc_time_counter

Overview:
- Free-running real-time calendar counter, directly upstream of the alarm/interrupt controller.
- Divides the system clock down to a 1 Hz tick and advances sec/min/hour/day-of-week/day-of-month/month/year with full calendar and leap-year rollover.
- Supports 24 h and 12 h modes and a validated software load.
- Its cur_* outputs drive the interrupt controller's current-time compare and snapshot inputs directly.

Parameters:
- CLK_FREQ_HZ, 32768, input clock cycles per second; prescaler terminal count is CLK_FREQ_HZ-1; must be ≥ 2.
- RESET_YEAR, 2000, year value after reset (0..4095).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; asynchronous, active-high
- set_i  in  1  one-cycle load strobe
- set_sec_i  in  6  load value, seconds
- set_min_i  in  6  load value, minutes
- set_hour_i  in  6  load value, hours
- set_mode_i  in  2  load value, mode
- set_day_of_week_i  in  3  load value, day of week
- set_day_of_month_i  in  5  load value, day of month
- set_month_i  in  4  load value, month
- set_year_i  in  12  load value, year
- cur_sec_o  out  6  0..59
- cur_min_o  out  6  0..59
- cur_hour_o  out  6  0..23 (24 h) or 1..12 (12 h)
- cur_mode_o  out  2  00 = 24 h, 10 = 12 h AM, 11 = 12 h PM; 01 reserved
- cur_day_of_week_o  out  3  0..6
- cur_day_of_month_o  out  5  1..28/29/30/31
- cur_month_o  out  4  1..12
- cur_year_o  out  12  0..4095
- sec_tick_o  out  1  one-cycle pulse on each second advance
- set_err_o  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (async assert, sync release):
  - time 00:00:00, mode 00, day_of_week 0, day_of_month 1, month 1, year RESET_YEAR
  - prescaler cleared; sec_tick_o = 0, set_err_o = 0
- Reset asserted mid-operation forces these values immediately; a set_i pulse in the same cycle is lost.
- Prescaler:
  - Counts 0..CLK_FREQ_HZ-1, then wraps to 0.
  - On the edge where it wraps, all time fields advance by 1 s and sec_tick_o is 1 for exactly that cycle. Outputs and tick are registered and change on the same edge.
  - First advance after reset: CLK_FREQ_HZ cycles after reset release.
- Second advance cascade, all evaluated in one cycle:
  - sec 59→0 with min+1; min 59→0 with hour+1.
  - 24 h: hour 23→0 with day advance.
  - 12 h: 11→12 toggles AM/PM (mode 10↔11). 12→1 keeps the meridiem. 11 PM→12 AM (mode 11→10) triggers day advance.
- Day advance:
  - day_of_week (n+1) mod 7.
  - day_of_month +1; if it was days_in_month, it becomes 1 and month +1.
  - month 12→1 with year +1; year 4095→0.
- days_in_month:
  - Apr/Jun/Sep/Nov = 30; Feb = 29 if leap else 28; others 31.
  - Leap year: (year % 4 == 0) && ((year % 100 != 0) || (year % 400 == 0)).
- Load (set_i = 1), evaluated on that edge:
  - Valid when all of the following hold:
    - sec < 60 and min < 60
    - mode ≠ 01
    - hour < 24 if mode 00, else 1..12
    - day_of_week < 7
    - month 1..12
    - day_of_month 1..days_in_month(set_month_i, set_year_i)
  - Valid: all fields take the set values; prescaler cleared to 0; no tick that cycle. The next advance occurs a full CLK_FREQ_HZ cycles later.
  - Invalid: no field changes and the prescaler keeps counting (a tick due that cycle still happens); set_err_o pulses for 1 cycle.
- Priority: a valid set_i beats a simultaneous prescaler wrap; that tick is dropped and sec_tick_o stays 0.
- Held set_i is treated as repeated loads: every cycle reloads and clears the prescaler, so the time freezes while set_i is high.
- Outputs are never driven from combinational logic on the set inputs; the loaded value is visible one cycle after set_i.

Test Plan:
- CLK_FREQ_HZ = 4, release reset -> cur_sec_o 0→1 on the 4th edge after release, with a 1-cycle sec_tick_o; 00:00:00, 1/1/2000, day_of_week 0 before that edge.
- Load 23:59:59, mode 00, 31 Dec 4095, day_of_week 6 -> next tick gives 00:00:00, 1 Jan, year 0, day_of_week 0.
- Load 28 Feb, at 23:59:59, in years 2024, 2100, 2000 and 2023 -> after the tick: 29 Feb (2024), 1 Mar (2100), 29 Feb (2000), 1 Mar (2023).
- 12 h mode:
  - 11:59:59 AM (mode 10) -> 12:00:00, mode 11.
  - 12:59:59 PM -> 01:00:00, mode 11.
  - 11:59:59 PM -> 12:00:00, mode 10, day advanced.
- Invalid loads -> set_err_o pulse, outputs unchanged, prescaler continues; cases:
  - 31 April
  - 29 Feb 2023
  - hour 0 in mode 10
  - mode 01
  - sec 60
- Valid set_i coincident with prescaler wrap -> set values appear with no advance and no tick; next tick CLK_FREQ_HZ cycles later. Assert rst_i mid-count -> outputs at reset values asynchronously.

Source files
------------

// File: rtl/rtc_time_counter.sv
// Real-time calendar counter: divides clk_i down to a 1 Hz tick and keeps
// sec/min/hour/day-of-week/day-of-month/month/year with leap-year rollover.
// Supports 24 h and 12 h (AM/PM) modes and a validated software load.
module rtc_time_counter #(
  parameter int unsigned CLK_FREQ_HZ = 32768,
  parameter int unsigned RESET_YEAR  = 2000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        set_i,
  input  logic [5:0]  set_sec_i,
  input  logic [5:0]  set_min_i,
  input  logic [5:0]  set_hour_i,
  input  logic [1:0]  set_mode_i,
  input  logic [2:0]  set_day_of_week_i,
  input  logic [4:0]  set_day_of_month_i,
  input  logic [3:0]  set_month_i,
  input  logic [11:0] set_year_i,
  output logic [5:0]  cur_sec_o,
  output logic [5:0]  cur_min_o,
  output logic [5:0]  cur_hour_o,
  output logic [1:0]  cur_mode_o,
  output logic [2:0]  cur_day_of_week_o,
  output logic [4:0]  cur_day_of_month_o,
  output logic [3:0]  cur_month_o,
  output logic [11:0] cur_year_o,
  output logic        sec_tick_o,
  output logic        set_err_o
);

  localparam int unsigned PW = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_FREQ_HZ - 1);
  localparam logic [11:0] RST_YEAR = 12'(RESET_YEAR);

  localparam logic [1:0] MODE_24H = 2'b00;
  localparam logic [1:0] MODE_AM  = 2'b10;
  localparam logic [1:0] MODE_PM  = 2'b11;
  localparam logic [1:0] MODE_BAD = 2'b01;

  // Gregorian leap rule; the constant moduli reduce to small comparators.
  function automatic logic is_leap(input logic [11:0] year);
    is_leap = (year[1:0] == 2'b00) &&
              (((year % 12'd100) != 12'd0) || ((year % 12'd400) == 12'd0));
  endfunction

  // Month length; an out-of-range month falls into the 31-day default.
  function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                               input logic [11:0] year);
    days_in_month = 5'd31;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
      4'd2:                    days_in_month = is_leap(year) ? 5'd29 : 5'd28;
      default:                 days_in_month = 5'd31;
    endcase
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic [1:0]    mode_q, mode_d;
  logic [2:0]    dow_q, dow_d;
  logic [4:0]    dom_q, dom_d;
  logic [3:0]    month_q, month_d;
  logic [11:0]   year_q, year_d;
  logic          tick_q, tick_d, err_q, err_d;

  logic          wrap;
  logic          set_valid;
  logic          hour_ok;
  logic          day_adv;
  logic [5:0]    adv_sec, adv_min, adv_hour;
  logic [1:0]    adv_mode;
  logic [2:0]    adv_dow;
  logic [4:0]    adv_dom;
  logic [3:0]    adv_month;
  logic [11:0]   adv_year;

  assign wrap = (presc_q == PRESC_TC);

  // Check every load field, including day-of-month against the loaded month/year.
  always_comb begin
    hour_ok = 1'b0;
    if (set_mode_i == MODE_24H) begin
      hour_ok = (set_hour_i < 6'd24);
    end else begin
      hour_ok = (set_hour_i >= 6'd1) && (set_hour_i <= 6'd12);
    end
    set_valid = (set_sec_i < 6'd60) && (set_min_i < 6'd60) &&
                (set_mode_i != MODE_BAD) && hour_ok &&
                (set_day_of_week_i < 3'd7) &&
                (set_month_i >= 4'd1) && (set_month_i <= 4'd12) &&
                (set_day_of_month_i != 5'd0) &&
                (set_day_of_month_i <= days_in_month(set_month_i, set_year_i));
  end

  // Compute the time one second later, cascading through all fields.
  always_comb begin
    adv_sec   = sec_q;
    adv_min   = min_q;
    adv_hour  = hour_q;
    adv_mode  = mode_q;
    adv_dow   = dow_q;
    adv_dom   = dom_q;
    adv_month = month_q;
    adv_year  = year_q;
    day_adv   = 1'b0;

    if (sec_q != 6'd59) begin
      adv_sec = sec_q + 6'd1;
    end else begin
      adv_sec = 6'd0;
      if (min_q != 6'd59) begin
        adv_min = min_q + 6'd1;
      end else begin
        adv_min = 6'd0;
        if (mode_q == MODE_24H) begin
          if (hour_q == 6'd23) begin
            adv_hour = 6'd0;
            day_adv  = 1'b1;
          end else begin
            adv_hour = hour_q + 6'd1;
          end
        end else begin
          if (hour_q == 6'd11) begin
            adv_hour = 6'd12;
            adv_mode = (mode_q == MODE_PM) ? MODE_AM : MODE_PM;
            day_adv  = (mode_q == MODE_PM);
          end else if (hour_q == 6'd12) begin
            adv_hour = 6'd1;
          end else begin
            adv_hour = hour_q + 6'd1;
          end
        end
      end
    end

    if (day_adv) begin
      adv_dow = (dow_q == 3'd6) ? 3'd0 : dow_q + 3'd1;
      if (dom_q == days_in_month(month_q, year_q)) begin
        adv_dom = 5'd1;
        if (month_q == 4'd12) begin
          adv_month = 4'd1;
          adv_year  = year_q + 12'd1;
        end else begin
          adv_month = month_q + 4'd1;
        end
      end else begin
        adv_dom = dom_q + 5'd1;
      end
    end
  end

  // Choose between a load, a one-second advance or plain prescaler counting.
  always_comb begin
    presc_d = wrap ? '0 : presc_q + PW'(1);
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    mode_d  = mode_q;
    dow_d   = dow_q;
    dom_d   = dom_q;
    month_d = month_q;
    year_d  = year_q;
    tick_d  = 1'b0;
    err_d   = 1'b0;

    if (set_i && set_valid) begin
      presc_d = '0;
      sec_d   = set_sec_i;
      min_d   = set_min_i;
      hour_d  = set_hour_i;
      mode_d  = set_mode_i;
      dow_d   = set_day_of_week_i;
      dom_d   = set_day_of_month_i;
      month_d = set_month_i;
      year_d  = set_year_i;
    end else begin
      err_d = set_i;
      if (wrap) begin
        sec_d   = adv_sec;
        min_d   = adv_min;
        hour_d  = adv_hour;
        mode_d  = adv_mode;
        dow_d   = adv_dow;
        dom_d   = adv_dom;
        month_d = adv_month;
        year_d  = adv_year;
        tick_d  = 1'b1;
      end
    end
  end

  // State registers; reset forces the calendar epoch immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q <= '0;
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hour_q  <= 6'd0;
      mode_q  <= MODE_24H;
      dow_q   <= 3'd0;
      dom_q   <= 5'd1;
      month_q <= 4'd1;
      year_q  <= RST_YEAR;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      mode_q  <= mode_d;
      dow_q   <= dow_d;
      dom_q   <= dom_d;
      month_q <= month_d;
      year_q  <= year_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  assign cur_sec_o          = sec_q;
  assign cur_min_o          = min_q;
  assign cur_hour_o         = hour_q;
  assign cur_mode_o         = mode_q;
  assign cur_day_of_week_o  = dow_q;
  assign cur_day_of_month_o = dom_q;
  assign cur_month_o        = month_q;
  assign cur_year_o         = year_q;
  assign sec_tick_o         = tick_q;
  assign set_err_o          = err_q;

endmodule
